// File: rtl/duck_round_ctrl.sv
// Purpose : game-flow controller for duck hunt. Sequences each duck through
//           spawn, flight, hit/escape pause; counts shots per duck and ducks
//           per game; turns mouse/start button levels into single edges.
// Ports   : clk, rst (sync, active-high); start, frame_tick, mouse_left,
//           duck_under_cursor in; spawn, duck_active, score_inc pulses/levels,
//           shots_left, duck_idx, hits counters, game_over out. All outputs
//           are registered.
module duck_round_ctrl #(
  parameter int SHOTS_PER_DUCK = 3,
  parameter int FLIGHT_FRAMES  = 300,
  parameter int PAUSE_FRAMES   = 60,
  parameter int DUCKS_PER_GAME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       mouse_left,
  input  logic       duck_under_cursor,
  output logic       spawn,
  output logic       duck_active,
  output logic       score_inc,
  output logic [1:0] shots_left,
  output logic [3:0] duck_idx,
  output logic [3:0] hits,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FLIGHT, S_HIT, S_MISS, S_OVER
  } state_t;

  localparam logic [1:0] SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
  localparam logic [9:0] FLIGHT_LAST = 10'(FLIGHT_FRAMES - 1);
  localparam logic [9:0] PAUSE_LAST  = 10'(PAUSE_FRAMES - 1);
  localparam logic [3:0] LAST_DUCK   = 4'(DUCKS_PER_GAME - 1);

  state_t     state, state_nxt;
  logic [9:0] frame_cnt, frame_cnt_nxt;
  logic [1:0] shots_nxt;
  logic [3:0] duck_idx_nxt, hits_nxt;
  logic       score_nxt;
  logic       mouse_prev, start_prev;
  logic       click, start_edge, shot_ok, escape, pause_done;

  // Rising-edge detection; the prev registers come out of reset high so a
  // button already held during reset never produces an edge.
  assign click      = mouse_left & ~mouse_prev;
  assign start_edge = start & ~start_prev;
  assign shot_ok    = click & (shots_left != 2'd0);
  assign escape     = frame_tick & (frame_cnt == FLIGHT_LAST);
  assign pause_done = frame_tick & (frame_cnt == PAUSE_LAST);

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    shots_nxt     = shots_left;
    duck_idx_nxt  = duck_idx;
    hits_nxt      = hits;
    score_nxt     = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          duck_idx_nxt = 4'd0;
          hits_nxt     = 4'd0;
          state_nxt    = S_SPAWN;
        end
      end
      S_SPAWN: begin
        shots_nxt     = SHOTS_INIT;
        frame_cnt_nxt = 10'd0;
        state_nxt     = S_FLIGHT;
      end
      S_FLIGHT: begin
        if (frame_tick) frame_cnt_nxt = frame_cnt + 10'd1;
        if (shot_ok) shots_nxt = shots_left - 2'd1;
        // A hit outranks both the last-shot miss and a coincident escape tick.
        if (shot_ok && duck_under_cursor) begin
          score_nxt     = 1'b1;
          hits_nxt      = hits + 4'd1;
          frame_cnt_nxt = 10'd0;
          state_nxt     = S_HIT;
        end else if ((shot_ok && shots_left == 2'd1) || escape) begin
          frame_cnt_nxt = 10'd0;
          state_nxt     = S_MISS;
        end
      end
      S_HIT, S_MISS: begin
        if (pause_done) begin
          frame_cnt_nxt = 10'd0;
          if (duck_idx == LAST_DUCK) begin
            state_nxt = S_OVER;
          end else begin
            duck_idx_nxt = duck_idx + 4'd1;
            state_nxt    = S_SPAWN;
          end
        end else if (frame_tick) begin
          frame_cnt_nxt = frame_cnt + 10'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Level outputs are decoded from the next state so they line up exactly
  // with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_cnt   <= 10'd0;
      shots_left  <= 2'd0;
      duck_idx    <= 4'd0;
      hits        <= 4'd0;
      mouse_prev  <= 1'b1;
      start_prev  <= 1'b1;
      spawn       <= 1'b0;
      duck_active <= 1'b0;
      score_inc   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      shots_left  <= shots_nxt;
      duck_idx    <= duck_idx_nxt;
      hits        <= hits_nxt;
      mouse_prev  <= mouse_left;
      start_prev  <= start;
      spawn       <= (state_nxt == S_SPAWN);
      duck_active <= (state_nxt == S_FLIGHT);
      score_inc   <= score_nxt;
      game_over   <= (state_nxt == S_OVER);
    end
  end

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Purpose : self-checking bench for duck_round_ctrl with default parameters.
//           A game-rule reference model predicts every change of the output
//           vector; a negedge monitor pops and compares each DUT change.
module tb_duck_round_ctrl;

  localparam int SHOTS = 3;
  localparam int FLIGHT = 300;
  localparam int PAUSE = 60;
  localparam int DUCKS = 10;

  localparam int M_IDLE = 0, M_SPAWN = 1, M_FLY = 2, M_PAUSE = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       rst, start, frame_tick, mouse_left, duck_under_cursor;
  logic       spawn, duck_active, score_inc, game_over;
  logic [1:0] shots_left;
  logic [3:0] duck_idx, hits;

  duck_round_ctrl #(
    .SHOTS_PER_DUCK(SHOTS), .FLIGHT_FRAMES(FLIGHT),
    .PAUSE_FRAMES(PAUSE), .DUCKS_PER_GAME(DUCKS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .mouse_left(mouse_left), .duck_under_cursor(duck_under_cursor),
    .spawn(spawn), .duck_active(duck_active), .score_inc(score_inc),
    .shots_left(shots_left), .duck_idx(duck_idx), .hits(hits),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int failed = 0;
  int n_score = 0;

  typedef struct {
    int          cyc;
    logic [13:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model (game rules, countdown form) ----------
  int          m_mode, m_flight_left, m_pause_left, m_shots, m_duck, m_hits;
  bit          m_score, m_mprev, m_sprev;
  logic [13:0] m_prev_vec;

  task automatic model_step(input bit r, input bit s, input bit t,
                            input bit m, input bit d);
    bit clicked, sedge;
    if (r) begin
      m_mode = M_IDLE; m_shots = 0; m_duck = 0; m_hits = 0;
      m_score = 0; m_mprev = 1; m_sprev = 1;
      return;
    end
    clicked = m && !m_mprev;
    sedge   = s && !m_sprev;
    m_mprev = m;
    m_sprev = s;
    m_score = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (sedge) begin
        m_duck = 0; m_hits = 0; m_mode = M_SPAWN;
      end
      M_SPAWN: begin
        m_mode = M_FLY; m_shots = SHOTS; m_flight_left = FLIGHT;
      end
      M_FLY: begin
        if (t) m_flight_left--;
        if (clicked && m_shots > 0) begin
          m_shots--;
          if (d) begin
            m_hits++; m_score = 1; m_mode = M_PAUSE; m_pause_left = PAUSE;
          end else if (m_shots == 0) begin
            m_mode = M_PAUSE; m_pause_left = PAUSE;
          end
        end
        if (m_mode == M_FLY && m_flight_left == 0) begin
          m_mode = M_PAUSE; m_pause_left = PAUSE;
        end
      end
      M_PAUSE: if (t) begin
        m_pause_left--;
        if (m_pause_left == 0) begin
          if (m_duck == DUCKS - 1) m_mode = M_OVER;
          else begin
            m_duck++; m_mode = M_SPAWN;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [13:0] model_vec();
    return {m_mode == M_SPAWN, m_mode == M_FLY, m_score, m_mode == M_OVER,
            2'(m_shots), 4'(m_duck), 4'(m_hits)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit r, input bit s, input bit t,
                     input bit m, input bit d);
    exp_t        e;
    logic [13:0] v;
    rst = r; start = s; frame_tick = t; mouse_left = m; duck_under_cursor = d;
    model_step(r, s, t, m, d);
    v = model_vec();
    if (v != m_prev_vec) begin
      e.cyc = cyc + 1;
      e.vec = v;
      exp_q.push_back(e);
      m_prev_vec = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic run_until(input int mode, input bit m, input bit d, input bit tick_en);
    int n = 0;
    while (m_mode != mode && n < 5000) begin
      drv(0, 0, tick_en ? 1'($urandom_range(0, 1)) : 1'b0, m, d);
      n++;
    end
    if (m_mode != mode) begin
      compared++;
      failed++;
      $display("FAIL run_until: mode %0d not reached in 5000 cycles", mode);
    end
  endtask

  task automatic press_start(input bit m, input bit d);
    drv(0, 0, 0, m, d);
    drv(0, 1, 0, m, d);
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  logic [13:0] mon_prev;

  always @(negedge clk) begin
    logic [13:0] dv;
    exp_t        e;
    if (mon_en) begin
      dv = {spawn, duck_active, score_inc, game_over, shots_left, duck_idx, hits};
      if (score_inc === 1'b1) n_score++;
      if (dv !== mon_prev) begin
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL out_event: cycle %0d got vec %h, required no change", cyc, dv);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== dv) begin
            failed++;
            $display("FAIL out_event: cycle %0d vec %h, required cycle %0d vec %h",
                     cyc, dv, e.cyc, e.vec);
          end
        end
        mon_prev = dv;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int  sc0;
    bit  s_lvl, m_lvl;
    rst = 1; start = 0; frame_tick = 0; mouse_left = 0; duck_under_cursor = 0;
    model_step(1, 0, 0, 0, 0);
    m_prev_vec = model_vec();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spawn", int'(spawn), 0);
    chk("rst_active", int'(duck_active), 0);
    chk("rst_score", int'(score_inc), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_shots", int'(shots_left), 0);
    chk("rst_idx", int'(duck_idx), 0);
    chk("rst_hits", int'(hits), 0);
    mon_prev = 14'd0;
    mon_en = 1;

    // Reset in mid-flight with the button held; held button must not score.
    press_start(0, 0);
    run_until(M_FLY, 0, 0, 1);
    repeat (3) drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0);
    chk("first_shot_dec", int'(shots_left), 2);
    drv(0, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 1);
    drv(1, 0, 0, 1, 1);
    chk("midflight_rst_active", int'(duck_active), 0);
    chk("midflight_rst_shots", int'(shots_left), 0);
    sc0 = n_score;
    press_start(1, 1);
    run_until(M_FLY, 1, 1, 1);
    repeat (20) drv(0, 0, 1'($urandom_range(0, 1)), 1, 1);
    chk("held_after_rst_no_score", n_score - sc0, 0);
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 1);
    chk("repress_score", int'(score_inc), 1);
    chk("repress_inactive", int'(duck_active), 0);

    // Hit in the 5th flight cycle, then a 60-tick pause.
    run_until(M_FLY, 0, 0, 1);
    repeat (4) drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 1);
    chk("hit5_score", int'(score_inc), 1);
    chk("hit5_hits", int'(hits), 2);
    drv(0, 0, 0, 0, 0);
    chk("score_single_cycle", int'(score_inc), 0);
    repeat (59) drv(0, 0, 1, 0, 0);
    chk("pause_59_no_spawn", int'(spawn), 0);
    drv(0, 0, 1, 0, 0);
    chk("pause_60_spawn", int'(spawn), 1);
    chk("pause_60_idx", int'(duck_idx), 2);

    // Three misses.
    run_until(M_FLY, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 1, 0);
      chk("miss_shots", int'(shots_left), 2 - k);
      drv(0, 0, 0, 0, 0);
    end
    chk("miss3_inactive", int'(duck_active), 0);
    chk("miss3_hits", int'(hits), 2);

    // Escape after exactly 300 ticks.
    run_until(M_FLY, 0, 0, 1);
    repeat (299) drv(0, 0, 1, 0, 0);
    chk("esc_299_active", int'(duck_active), 1);
    drv(0, 0, 1, 0, 0);
    chk("esc_300_inactive", int'(duck_active), 0);
    chk("esc_no_score", int'(score_inc), 0);

    // Hit coincident with the escaping tick.
    run_until(M_FLY, 0, 0, 1);
    repeat (299) drv(0, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 1);
    chk("coinc_score", int'(score_inc), 1);
    chk("coinc_hits", int'(hits), 3);

    // Button held 1000 cycles over the duck.
    run_until(M_FLY, 0, 0, 1);
    sc0 = n_score;
    repeat (1000) drv(0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0);
    chk("held_1000_one_score", n_score - sc0, 1);

    // Full game, every duck hit.
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    press_start(0, 0);
    sc0 = n_score;
    for (int d = 0; d < DUCKS; d++) begin
      run_until(M_FLY, 0, 0, 1);
      drv(0, 0, 0, 1, 1);
      drv(0, 0, 0, 0, 0);
    end
    run_until(M_OVER, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("game_scores", n_score - sc0, DUCKS);
    chk("game_hits", int'(hits), DUCKS);
    chk("game_over", int'(game_over), 1);
    chk("game_last_idx", int'(duck_idx), DUCKS - 1);
    press_start(0, 0);
    chk("restart_spawn", int'(spawn), 1);
    chk("restart_idx", int'(duck_idx), 0);
    chk("restart_hits", int'(hits), 0);

    // Random play.
    s_lvl = 0;
    m_lvl = 0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 199) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 5) == 0) m_lvl = ~m_lvl;
      drv(1'($urandom_range(0, 2999) == 0), s_lvl, 1'($urandom_range(0, 1)),
          m_lvl, 1'($urandom_range(0, 1)));
    end

    repeat (4) drv(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/duck_round_ctrl.md
# duck_round_ctrl

Game-flow controller for the duck-hunt game. Sequences each duck's life (spawn, flight, hit/escape, pause) and counts shots per duck and ducks per game. Converts raw mouse-button levels into single-click events. Issues the one-cycle `score_inc` pulse consumed by the score counter. Sits between the mouse/hit-detection logic and the score counter and duck motion block, in the `clk` domain.

## Interface
Parameters:
- SHOTS_PER_DUCK, 3, shots allowed per duck (1..3)
- FLIGHT_FRAMES, 300, frame ticks before an unhit duck escapes (1..1023)
- PAUSE_FRAMES, 60, frame ticks spent in HIT/MISS pause (1..1023)
- DUCKS_PER_GAME, 10, ducks per game (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  game start button level (already synchronized)
- frame_tick  in  1  one-cycle pulse per video frame
- mouse_left  in  1  left button level (already synchronized)
- duck_under_cursor  in  1  level; cursor inside current duck's box
- spawn  out  1  one-cycle pulse; duck motion block reloads start position
- duck_active  out  1  duck visible and shootable
- score_inc  out  1  one-cycle pulse per hit, to score counter
- shots_left  out  2  remaining shots for current duck
- duck_idx  out  4  index of current duck, 0-based
- hits  out  4  ducks hit this game
- game_over  out  1  high while in OVER

## Operation
- All outputs registered. Internal state: FSM, frame_cnt (10 bit), mouse_prev, start_prev.
- click = mouse_left & ~mouse_prev; start_edge = start & ~start_prev. Both prev registers load every cycle.
- States: IDLE, SPAWN, FLIGHT, HIT, MISS, OVER.
- IDLE: on start_edge, clear duck_idx, hits → SPAWN.
- SPAWN (exactly 1 cycle): spawn=1, shots_left←SHOTS_PER_DUCK, frame_cnt←0 → FLIGHT.
- FLIGHT: duck_active=1.
  - On click with shots_left>0: shots_left decrements.
  - If duck_under_cursor in the click cycle: score_inc=1, hits+1, frame_cnt←0 → HIT.
  - Else if this was the last shot: frame_cnt←0 → MISS.
  - On frame_tick, frame_cnt increments. frame_tick when frame_cnt==FLIGHT_FRAMES-1: frame_cnt←0 → MISS.
- HIT/MISS: duck_active=0; count frame_ticks.
  - On tick with frame_cnt==PAUSE_FRAMES-1: if duck_idx==DUCKS_PER_GAME-1 → OVER, else duck_idx+1 → SPAWN.
- OVER: game_over=1, counters held. start_edge clears duck_idx, hits → SPAWN (new game; score reset is the top level's job).

## Timing
- Reset (any state, including mid-flight): state IDLE; spawn, duck_active, score_inc, game_over, shots_left, duck_idx, hits, frame_cnt = 0.
- Reset sets mouse_prev=1 and start_prev=1, so a button held through reset is not an edge.
- Click latency: mouse_left rises in cycle N. In cycle N+1, score_inc=1 and state HIT (duck_active=0), or shots_left is decremented.
- score_inc is high for exactly one cycle per hit, never in consecutive cycles. A held button yields one click.
- Simultaneous click-hit and escape tick in FLIGHT: hit wins (score_inc=1, HIT).
- Simultaneous click-miss on the last shot and escape tick: → MISS once, with frame_cnt=0.
- Clicks outside FLIGHT are ignored and change no counter.
- spawn precedes duck_active by one cycle. The first FLIGHT cycle is the one after spawn.
- hits ≤ duck_idx+1 always; no wrap within parameter range.

## Test plan
- Reset mid-FLIGHT with mouse_left held high → all outputs 0, IDLE; no score_inc after reset until the button is released and pressed again.
- start edge; click with duck_under_cursor=1 in the 5th FLIGHT cycle → score_inc one cycle later for 1 cycle, hits=1, HIT. After 60 ticks: spawn pulse, duck_idx=1.
- Three clicks with duck_under_cursor=0 → shots_left 3→2→1→0, MISS after third click, hits unchanged.
- No clicks; 300 frame_ticks → MISS on 300th tick. Click-hit coincident with the 300th tick → HIT, score_inc=1.
- Full game, DUCKS_PER_GAME=10, every duck hit → 10 score_inc pulses, hits=10, game_over=1. New start edge → duck_idx=0, hits=0, spawn.
- mouse_left held 1000 cycles in FLIGHT over duck → exactly one score_inc.
